// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT frame scheduler.
//   FFT_N          points per frame
//   FFT_BLK        samples per block (one block per cycle)
//   FFT_NBLK       blocks per frame
//   FFT_BLK_IDX_W  width of a block index
//   fft_ctrl_state_t  frame scheduler FSM states
package fft_pkg;

    localparam int unsigned FFT_N         = 512;
    localparam int unsigned FFT_BLK       = 16;
    localparam int unsigned FFT_NBLK      = 32;
    localparam int unsigned FFT_BLK_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } fft_ctrl_state_t;

endpackage

// File: rtl/fft_blk_counter.sv
// fft_blk_counter: block index up counter with synchronous clear and enable.
// Counts 0..Last and wraps to 0; tc_o flags that the count is at Last.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   clr_i  clear to 0 (has priority over en_i)
//   en_i   advance by one
//   cnt_o  current count
//   tc_o   terminal count (cnt_o == Last)
module fft_blk_counter
    import fft_pkg::*;
#(
    parameter int unsigned Width = FFT_BLK_IDX_W,
    parameter int unsigned Last  = FFT_NBLK - 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == Width'(Last));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame scheduler in front of the block-parallel FFT datapath.
// On start it reads all blocks of one frame from the sample buffer as one
// contiguous burst, then counts the output blocks back and pulses done.
// Optional feature: define FFT_FRAME_CTRL_TIMEOUT_EN to build a DRAIN watchdog
// that aborts a frame (err set, no done) after TIMEOUT_CYC cycles without output.
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   start         frame request, sampled only in IDLE
//   busy          high in FEED and DRAIN
//   done          one-cycle pulse after the last output block
//   err           sticky error: stray output or watchdog timeout
//   rd_en         sample-buffer read enable (data returns one cycle later)
//   rd_addr       block index being read
//   fft_valid_in  rd_en delayed one cycle, to FFT valid_in
//   fft_valid_out FFT valid_out, one per output block
//   out_blk_idx   index of the current output block
//   out_last      fft_valid_out on the final block
//   frame_cnt     completed frames, wrapping
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N_POINT     = FFT_N,
    parameter int unsigned BLK_SIZE    = FFT_BLK,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rd_en,
    output logic [4:0]  rd_addr,
    output logic        fft_valid_in,
    input  logic        fft_valid_out,
    output logic [4:0]  out_blk_idx,
    output logic        out_last,
    output logic [15:0] frame_cnt
);

    localparam int unsigned NBLK = N_POINT / BLK_SIZE;

    fft_ctrl_state_t state_q, state_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            valid_in_q;

    logic [FFT_BLK_IDX_W-1:0] in_cnt, out_cnt;
    logic                     in_tc, out_tc;
    logic                     accept, out_en, frame_end, wdog_hit;

    assign accept    = (state_q == IDLE) && start;
    assign out_en    = fft_valid_out && (state_q != IDLE);
    assign frame_end = out_en && out_tc;

    fft_blk_counter #(
        .Width (FFT_BLK_IDX_W),
        .Last  (NBLK - 1)
    ) u_in_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (accept),
        .en_i  (state_q == FEED),
        .cnt_o (in_cnt),
        .tc_o  (in_tc)
    );

    fft_blk_counter #(
        .Width (FFT_BLK_IDX_W),
        .Last  (NBLK - 1)
    ) u_out_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (accept),
        .en_i  (out_en),
        .cnt_o (out_cnt),
        .tc_o  (out_tc)
    );

`ifdef FFT_FRAME_CTRL_TIMEOUT_EN
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYC + 1);

    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             drain_idle;

    // Counts consecutive DRAIN cycles with no output; any output restarts it.
    assign drain_idle = (state_q == DRAIN) && !fft_valid_out;
    assign wdog_hit   = drain_idle && (wdog_q == WdogW'(TIMEOUT_CYC - 1));
    assign wdog_d     = drain_idle ? wdog_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FEED;
                    err_d   = 1'b0;
                end
                if (fft_valid_out) begin
                    err_d = 1'b1;
                end
            end
            FEED: begin
                // Completion wins over the feed: any remaining reads are dropped.
                if (frame_end) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else if (in_tc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_end) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else if (wdog_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            valid_in_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            valid_in_q  <= rd_en;
        end
    end

    assign busy         = (state_q != IDLE);
    assign rd_en        = (state_q == FEED);
    assign rd_addr      = in_cnt;
    assign fft_valid_in = valid_in_q;
    assign out_blk_idx  = out_cnt;
    assign out_last     = fft_valid_out && out_tc;
    assign done         = done_q;
    assign err          = err_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
